jk_bank_driver: RTL and testbench

- Excitation-side controller for a bank of JK flip-flops: it computes the J/K inputs that move the bank to a requested value.
- It accepts a target word over a valid/ready handshake and drives per-bit J/K vectors into the bank for one clock.
- It then checks the bank's Q feedback against the target, retries on mismatch, and reports done or error.
- It sits between a control/sequencing block and any WIDTH-wide bank of async-reset JK flip-flops.

---
 rtl/jk_bank_driver.sv | 127 ++++++++++++
 tb/tb_jk_bank_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: excitation controller for a WIDTH-wide bank of JK flip-flops.
// Accepts a target word, drives J/K for one cycle, then checks the bank's Q
// feedback. On a mismatch it retries up to MAX_RETRIES times, then reports
// done or err.
module jk_bank_driver #(
  parameter  int WIDTH       = 8,
  parameter  int MAX_RETRIES = 3,
  localparam int AW          = $clog2(MAX_RETRIES + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic             tgt_mode,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AW-1:0]    attempts
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  localparam logic [AW-1:0] MAX_R = AW'(MAX_RETRIES);
  localparam logic [AW-1:0] ONE   = AW'(1);

  state_t           state_q;
  logic [WIDTH-1:0] tgt_q;
  logic             mode_q;
  logic [AW-1:0]    retry_q;
  logic [WIDTH-1:0] j_q, k_q;
  logic             done_q, err_q;
  logic [AW-1:0]    attempts_q;

  logic [WIDTH-1:0] src_tgt_d;
  logic             src_mode_d;
  logic [WIDTH-1:0] j_d, k_d;

  // Force mode sets or clears every bit, so the pair {J,K} is never 11.
  // Toggle mode flips only the bits that differ from the target, so the
  // pair is either 00 or 11.
  function automatic logic [2*WIDTH-1:0] jk_encode(input logic [WIDTH-1:0] t,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic             mode);
    logic [WIDTH-1:0] diff;
    diff = t ^ q;
    if (mode) jk_encode = {diff, diff};
    else      jk_encode = {t, ~t};
  endfunction

  // J/K excitation for the next DRIVE cycle: from the incoming request when
  // accepting it, otherwise from the captured target on a retry.
  always_comb begin
    src_tgt_d  = (state_q == S_IDLE) ? tgt_data : tgt_q;
    src_mode_d = (state_q == S_IDLE) ? tgt_mode : mode_q;
    {j_d, k_d} = jk_encode(src_tgt_d, q_fb, src_mode_d);
  end

  // Control FSM with registered J/K and status outputs. J/K default to 0 so
  // the bank holds in every cycle except DRIVE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tgt_q      <= '0;
      mode_q     <= 1'b0;
      retry_q    <= '0;
      j_q        <= '0;
      k_q        <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      attempts_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      j_q    <= '0;
      k_q    <= '0;
      case (state_q)
        S_IDLE: begin
          if (tgt_valid) begin
            tgt_q   <= tgt_data;
            mode_q  <= tgt_mode;
            retry_q <= '0;
            j_q     <= j_d;
            k_q     <= k_d;
            state_q <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (q_fb == tgt_q) begin
            done_q     <= 1'b1;
            attempts_q <= retry_q + ONE;
            state_q    <= S_IDLE;
          end else if (retry_q < MAX_R) begin
            retry_q <= retry_q + ONE;
            j_q     <= j_d;
            k_q     <= k_d;
            state_q <= S_DRIVE;
          end else begin
            err_q      <= 1'b1;
            attempts_q <= retry_q + ONE;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tgt_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign j_out     = j_q;
  assign k_out     = k_q;
  assign done      = done_q;
  assign err       = err_q;
  assign attempts  = attempts_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench for jk_bank_driver with a behavioural JK bank in the loop.
module tb_jk_bank_driver;

  localparam int WIDTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             tgt_valid = 1'b0;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data = '0;
  logic             tgt_mode = 1'b0;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j_out, k_out;
  logic             busy, done, err;
  logic [AW-1:0]    attempts;

  // Bank model state
  logic [WIDTH-1:0] bank_q = '0;
  logic [WIDTH-1:0] stuck0 = '0;
  logic             ld_en = 1'b0;
  logic [WIDTH-1:0] ld_val = '0;

  int n_tests = 0;
  int n_fail  = 0;

  jk_bank_driver #(.WIDTH(WIDTH), .MAX_RETRIES(3)) dut (
    .clk(clk), .reset(reset),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .tgt_data(tgt_data), .tgt_mode(tgt_mode),
    .q_fb(q_fb), .j_out(j_out), .k_out(k_out),
    .busy(busy), .done(done), .err(err), .attempts(attempts)
  );

  always #5 clk = ~clk;

  // JK bank: set/reset/toggle/hold per bit; optional direct load for setup.
  always @(posedge clk) begin
    if (ld_en) bank_q <= ld_val;
    else begin
      for (int b = 0; b < WIDTH; b++) begin
        case ({j_out[b], k_out[b]})
          2'b10:   bank_q[b] <= 1'b1;
          2'b01:   bank_q[b] <= 1'b0;
          2'b11:   bank_q[b] <= ~bank_q[b];
          default: bank_q[b] <= bank_q[b];
        endcase
      end
    end
  end

  assign q_fb = bank_q & ~stuck0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_bank(input logic [WIDTH-1:0] v);
    @(negedge clk);
    ld_en  = 1'b1;
    ld_val = v;
    @(negedge clk);
    ld_en  = 1'b0;
  endtask

  // Presents a request for one accept edge; returns at the negedge of cycle 1.
  task automatic start_req(input logic [WIDTH-1:0] d, input logic m);
    @(negedge clk);
    tgt_valid = 1'b1;
    tgt_data  = d;
    tgt_mode  = m;
    @(posedge clk);
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_j", 32'(j_out), 32'h00);
    check("rst_k", 32'(k_out), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(tgt_ready), 32'd1);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_attempts", 32'(attempts), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1: force mode 8'hA5 from 8'h00
    load_bank(8'h00);
    start_req(8'hA5, 1'b0);
    check("t1_j_c1", 32'(j_out), 32'hA5);
    check("t1_k_c1", 32'(k_out), 32'h5A);
    check("t1_ready_c1", 32'(tgt_ready), 32'd0);
    check("t1_busy_c1", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_jk_c2", 32'({j_out, k_out}), 32'h0000);
    check("t1_ready_c2", 32'(tgt_ready), 32'd0);
    check("t1_done_c2", 32'(done), 32'd0);
    @(negedge clk);
    check("t1_done_c3", 32'(done), 32'd1);
    check("t1_err_c3", 32'(err), 32'd0);
    check("t1_attempts", 32'(attempts), 32'd1);
    check("t1_ready_c3", 32'(tgt_ready), 32'd1);
    check("t1_bank", 32'(q_fb), 32'hA5);
    @(negedge clk);
    check("t1_done_c4", 32'(done), 32'd0);

    // 2: toggle mode 8'h0F from 8'hF0
    load_bank(8'hF0);
    start_req(8'h0F, 1'b1);
    check("t2_j_c1", 32'(j_out), 32'hFF);
    check("t2_k_c1", 32'(k_out), 32'hFF);
    @(negedge clk);
    check("t2_q_c2", 32'(q_fb), 32'h0F);
    @(negedge clk);
    check("t2_done_c3", 32'(done), 32'd1);
    check("t2_attempts", 32'(attempts), 32'd1);

    // 3: bit 3 stuck at 0, retries exhausted
    load_bank(8'h00);
    stuck0 = 8'h08;
    start_req(8'h08, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) @(negedge clk);
      if (c < 9 && (c % 2) == 1) begin
        check($sformatf("t3_j_c%0d", c), 32'(j_out), 32'h08);
        check($sformatf("t3_k_c%0d", c), 32'(k_out), 32'hF7);
      end else if (c < 9) begin
        check($sformatf("t3_jk_c%0d", c), 32'({j_out, k_out}), 32'h0000);
      end
      check($sformatf("t3_done_c%0d", c), 32'(done), 32'd0);
      check($sformatf("t3_err_c%0d", c), 32'(err), (c == 9) ? 32'd1 : 32'd0);
    end
    check("t3_attempts", 32'(attempts), 32'd4);
    check("t3_ready", 32'(tgt_ready), 32'd1);
    @(negedge clk);
    check("t3_err_once", 32'(err), 32'd0);
    stuck0 = 8'h00;

    // 4: toggle mode, target already present
    load_bank(8'h3C);
    start_req(8'h3C, 1'b1);
    check("t4_jk_c1", 32'({j_out, k_out}), 32'h0000);
    check("t4_busy_c1", 32'(busy), 32'd1);
    @(negedge clk);
    check("t4_jk_c2", 32'({j_out, k_out}), 32'h0000);
    @(negedge clk);
    check("t4_done_c3", 32'(done), 32'd1);
    check("t4_attempts", 32'(attempts), 32'd1);

    // 5: reset during DRIVE
    load_bank(8'h00);
    start_req(8'hFF, 1'b0);
    check("t5_j_c1", 32'(j_out), 32'hFF);
    #1 reset = 1'b0;
    #1;
    check("t5_j_async", 32'(j_out), 32'h00);
    check("t5_k_async", 32'(k_out), 32'h00);
    check("t5_busy_rst", 32'(busy), 32'd0);
    check("t5_attempts_rst", 32'(attempts), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    check("t5_ready_rel", 32'(tgt_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t5_no_status_%0d", c), 32'({done, err}), 32'd0);
    end
    check("t5_bank_held", 32'(q_fb), 32'h00);
    start_req(8'h5A, 1'b0);
    check("t5_j_new", 32'(j_out), 32'h5A);
    @(negedge clk);
    @(negedge clk);
    check("t5_done_new", 32'(done), 32'd1);
    check("t5_bank_new", 32'(q_fb), 32'h5A);

    // 6: back-to-back with held valid, stray valid while busy
    load_bank(8'h00);
    @(negedge clk);
    tgt_valid = 1'b1;
    tgt_data  = 8'h11;
    tgt_mode  = 1'b0;
    @(negedge clk);                       // cycle 1
    tgt_data = 8'h22;
    check("t6_j_a", 32'(j_out), 32'h11);
    @(negedge clk);                       // cycle 2
    check("t6_ready_c2", 32'(tgt_ready), 32'd0);
    @(negedge clk);                       // cycle 3: done for 8'h11, 8'h22 accepted here
    check("t6_done_a", 32'(done), 32'd1);
    check("t6_ready_c3", 32'(tgt_ready), 32'd1);
    @(negedge clk);                       // cycle 4: DRIVE for 8'h22
    check("t6_j_b", 32'(j_out), 32'h22);
    check("t6_k_b", 32'(k_out), 32'hDD);
    check("t6_done_c4", 32'(done), 32'd0);
    tgt_data = 8'hFF;                     // stray request while busy
    @(negedge clk);                       // cycle 5: CHECK
    check("t6_jk_c5", 32'({j_out, k_out}), 32'h0000);
    @(negedge clk);                       // cycle 6
    tgt_valid = 1'b0;
    check("t6_done_b", 32'(done), 32'd1);
    check("t6_bank_b", 32'(q_fb), 32'h22);
    @(negedge clk);                       // cycle 7
    check("t6_idle_after", 32'(busy), 32'd0);
    check("t6_no_stray_j", 32'(j_out), 32'h00);
    @(negedge clk);
    check("t6_bank_final", 32'(q_fb), 32'h22);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: directed flow is short; any overrun is a failure.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
